tx_mac_frame_arbiter: RTL
=========================

Name: tx_mac_frame_arbiter

Overview:
- Frame-granular round-robin arbiter. Shares the single AXI-Stream input of tx_mac between NUM_PORTS frame sources.
- Holds a grant from the first beat to tlast, so frames never interleave. Inserts a configurable idle gap between frames.
- Enforces a maximum frame length: an oversize frame is truncated and its tail discarded.
- Sits directly upstream of tx_mac. The m_axis_* outputs connect to tx_mac s_axis_*.

Parameters:
- NUM_PORTS, 4, number of requesters; 2..8.
- DATA_WIDTH, 32, AXI-Stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- GAP_CYCLES, 1, idle cycles forced after each frame before re-arbitration; 0..15.
- MAX_FRAME_WORDS, 400, maximum beats per frame; must be ≥2.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  packed per-port data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  packed per-port byte keep.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_trdy  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to tx_mac.
- m_axis_tkeep  out  KEEP_WIDTH  to tx_mac.
- m_axis_tvalid  out  1  to tx_mac.
- m_axis_tlast  out  1  to tx_mac.
- m_axis_trdy  in  1  ready from tx_mac.
- o_grant  out  NUM_PORTS  one-hot current grant; 0 when no grant is held.
- o_busy  out  1  high in XFER, DROP and GAP.
- o_oversize  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (i_reset_n = 1, asynchronous):
  - State = IDLE; o_grant = 0; all s_axis_trdy = 0; m_axis_tvalid = m_axis_tlast = 0; m_axis_tdata/tkeep = 0; o_busy = 0; o_oversize = 0.
  - Beat counter = 0; gap counter = 0.
  - Last-grant pointer = NUM_PORTS-1, so port 0 has first priority.
  - Reset mid-frame discards the frame silently. No tlast is emitted.
- A beat is a cycle in which valid and ready are both high on the same interface.
- State IDLE:
  - All s_axis_trdy = 0; m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, register grant = first requesting port searching upward from (last_grant+1) mod NUM_PORTS. Update last_grant, clear the beat counter, go to XFER.
  - Arbitration latency is 1 cycle: tvalid seen in IDLE, data passes in the next cycle.
- State XFER:
  - Combinational pass-through with zero added latency: m_axis_{tdata,tkeep,tvalid,tlast} = port[grant].
  - s_axis_trdy[grant] = m_axis_trdy; all other s_axis_trdy = 0.
  - Requests from other ports are ignored until the grant is released.
  - Beat counter increments on each beat and saturates.
  - A beat with tlast releases the grant: go to GAP if GAP_CYCLES > 0, otherwise to IDLE.
  - Truncation: a beat that is the MAX_FRAME_WORDS-th beat without source tlast drives m_axis_tlast = 1 on that beat and pulses o_oversize in the following cycle.
    - If the source's tlast is not on that beat, go to DROP.
    - If the source's tlast coincides with that beat, treat it as normal completion with no o_oversize.
- State DROP:
  - m_axis_tvalid = 0; s_axis_trdy[grant] = 1.
  - Source beats are consumed and discarded until a beat with tlast, then go to GAP or IDLE as in XFER.
- State GAP:
  - All readies = 0; m_axis_tvalid = 0; o_grant = 0.
  - Stay GAP_CYCLES cycles, then go to IDLE.
- m_axis_trdy low while a beat is pending: outputs hold stable and the source is stalled through trdy. The grant is never dropped mid-frame.
- o_grant is registered; it is one-hot in XFER/DROP and 0 in IDLE/GAP.
- A source lowering tvalid mid-frame (bubble) keeps the grant. No timeout applies.
- Round-robin fairness: with all ports continuously requesting, grants rotate 0,1,…,NUM_PORTS-1,0.

Test Plan:
- Single port 2 sends a 16-beat frame, m_axis_trdy = 1, GAP_CYCLES = 1 → m_axis output identical, tlast on beat 16; o_grant = 4'b0100 during the frame; o_busy low 2 cycles after tlast.
- Ports 0–3 all request continuously, 3 frames each of 15 beats → grant order 0,1,2,3,0,1,2,3,…; no interleaving; 12 frames total; each frame's payload matches its source.
- Port 1 frame of MAX_FRAME_WORDS+10 beats → output has exactly MAX_FRAME_WORDS beats with tlast on the last; o_oversize pulses once; 10 trailing beats are accepted and discarded; next frame starts clean.
- Random m_axis_trdy deasserted 30% of cycles, loopback through tx_mac/rx_mac, 100 frames across 4 ports → scoreboard matches every frame, padded to 15 words minimum.
- Assert i_reset_n mid-frame on port 3 → all outputs 0 immediately; after release, port 0 wins first arbitration if requesting together with port 3.
- Frame of exactly MAX_FRAME_WORDS beats with tlast on the final beat → passed intact, o_oversize stays 0, no DROP.

Source files
------------

// File: rtl/tx_mac_frame_arbiter.sv
// Frame-granular round-robin arbiter that funnels NUM_PORTS AXI-Stream sources into tx_mac.
// Grants are held for a whole frame; oversize frames are cut at MAX_FRAME_WORDS and their tail is dropped.
module tx_mac_frame_arbiter #(
    parameter int unsigned NUM_PORTS       = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned GAP_CYCLES      = 1,
    parameter int unsigned MAX_FRAME_WORDS = 400
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_trdy,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_trdy,
    output logic [NUM_PORTS-1:0]             o_grant,
    output logic                             o_busy,
    output logic                             o_oversize
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_FRAME_WORDS + 1);
    localparam int unsigned GAP_W = 4;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_FRAME_WORDS);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] PORT_LAST = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   beat_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid;
    logic                  sel_last;

    logic                  arb_found;
    logic [IDX_W-1:0]      arb_idx;
    logic [IDX_W-1:0]      cand;

    logic                  at_max;
    logic                  xfer_beat;
    logic                  drop_beat;
    logic                  frame_done;

    // Mux of the currently granted source
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_data  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid = s_axis_tvalid[k];
                sel_last  = s_axis_tlast[k];
            end
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant;
        cand      = last_grant;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((32'(last_grant) + off) % NUM_PORTS);
            if (!arb_found && s_axis_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign at_max     = (beat_cnt == LAST_BEAT);
    assign xfer_beat  = (state == XFER) && sel_valid && m_axis_trdy;
    assign drop_beat  = (state == DROP) && sel_valid;
    assign frame_done = (xfer_beat || drop_beat) && sel_last;

    // Zero-latency datapath: source to tx_mac while in XFER, sink-only while in DROP
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_trdy   = '0;
        case (state)
            XFER: begin
                m_axis_tdata           = sel_data;
                m_axis_tkeep           = sel_keep;
                m_axis_tvalid          = sel_valid;
                m_axis_tlast           = sel_last || at_max;
                s_axis_trdy[grant_idx] = m_axis_trdy;
            end
            DROP: begin
                s_axis_trdy[grant_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset_n) begin
        if (i_reset_n) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= PORT_LAST;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            o_oversize <= 1'b0;
        end else begin
            o_oversize <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_idx  <= arb_idx;
                        last_grant <= arb_idx;
                        o_grant    <= NUM_PORTS'(1) << arb_idx;
                        beat_cnt   <= '0;
                        o_busy     <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_beat) begin
                        if (beat_cnt != CNT_SAT) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                        // Cut at the limit unless the source ends right here anyway
                        if (!sel_last && at_max) begin
                            o_oversize <= 1'b1;
                            state      <= DROP;
                        end
                    end
                end
                DROP: ;
                GAP: begin
                    if (gap_cnt == '0) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (frame_done) begin
                o_grant <= '0;
                if (GAP_CYCLES > 0) begin
                    gap_cnt <= GAP_LOAD;
                    state   <= GAP;
                end else begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            end
        end
    end

endmodule
